// File: rtl/sa_psum_collector.sv
// Purpose: deskews systolic-array psum lanes into whole rows, buffers them, and tracks tile completion.
// Latency: lane 0 valid in cycle t gives out_valid_o in cycle t+PE_SIZE when the buffer is empty.
// Backpressure: out_ready_i low holds rows in the FIFO; a complete row arriving while it is full is dropped and flagged.
module sa_psum_collector #(
  parameter int PE_SIZE    = 2,
  parameter int PSUM_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PSUM_WIDTH*PE_SIZE-1:0]  psum_row_i,
  input  logic [PE_SIZE-1:0]             psum_en_row_i,
  input  logic                           start_i,
  input  logic [15:0]                    tile_rows_i,
  output logic [PSUM_WIDTH*PE_SIZE-1:0]  out_row_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           overflow_o,
  output logic                           align_err_o
);

  localparam int RW = PSUM_WIDTH * PE_SIZE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Aligned row, same lane packing as the input (lane 0 in the MSB slice).
  logic [RW-1:0]      aln_row;
  logic [PE_SIZE-1:0] aln_en;

  // Lane j waits PE_SIZE-1-j cycles so every lane of a row meets the last lane.
  for (genvar j = 0; j < PE_SIZE; j++) begin : g_lane
    localparam int NSTG = PE_SIZE - 1 - j;

    logic [PSUM_WIDTH-1:0] in_dat;
    logic                  in_en;

    assign in_dat = psum_row_i[PSUM_WIDTH*(PE_SIZE-j)-1 -: PSUM_WIDTH];
    assign in_en  = psum_en_row_i[PE_SIZE-1-j];

    if (NSTG == 0) begin : g_pass
      assign aln_row[PSUM_WIDTH*(PE_SIZE-j)-1 -: PSUM_WIDTH] = in_dat;
      assign aln_en[PE_SIZE-1-j]                             = in_en;
    end else begin : g_dly
      logic [PSUM_WIDTH-1:0] stg_dat [NSTG];
      logic                  stg_en  [NSTG];

      // Delay line for this lane; a tile start flushes any half-formed rows.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < NSTG; k++) begin
            stg_dat[k] <= '0;
            stg_en[k]  <= 1'b0;
          end
        end else if (start_i) begin
          for (int k = 0; k < NSTG; k++) begin
            stg_dat[k] <= '0;
            stg_en[k]  <= 1'b0;
          end
        end else begin
          stg_dat[0] <= in_dat;
          stg_en[0]  <= in_en;
          for (int k = 1; k < NSTG; k++) begin
            stg_dat[k] <= stg_dat[k-1];
            stg_en[k]  <= stg_en[k-1];
          end
        end
      end

      assign aln_row[PSUM_WIDTH*(PE_SIZE-j)-1 -: PSUM_WIDTH] = stg_dat[NSTG-1];
      assign aln_en[PE_SIZE-1-j]                             = stg_en[NSTG-1];
    end
  end

  // FIFO state
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [RW-1:0] row_hold_q;

  // Row classification and FIFO handshakes; start_i suppresses both push and pop.
  logic all_en;
  logic any_en;
  logic push_req;
  logic mis_evt;
  logic fifo_full;
  logic pop;
  logic wr_en;
  logic ovf_evt;

  assign all_en    = &aln_en;
  assign any_en    = |aln_en;
  assign push_req  = all_en & ~start_i;
  assign mis_evt   = any_en & ~all_en & ~start_i;
  assign fifo_full = (fifo_cnt_q == CW'(FIFO_DEPTH));
  assign pop       = out_valid_o & out_ready_i & ~start_i;
  assign wr_en     = push_req & (~fifo_full | pop);
  assign ovf_evt   = push_req & fifo_full & ~pop;

  assign out_valid_o = (fifo_cnt_q != '0);
  assign out_row_o   = out_valid_o ? mem[rd_ptr_q] : row_hold_q;

  // Storage array; needs no reset because reads are gated by the count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= aln_row;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keeps the count, even when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (start_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (wr_en && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + CW'(1);
      end else if (!wr_en && pop) begin
        fifo_cnt_q <= fifo_cnt_q - CW'(1);
      end
    end
  end

  // Remember the last presented head so out_row_o is stable while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_hold_q <= '0;
    end else if (out_valid_o) begin
      row_hold_q <= mem[rd_ptr_q];
    end
  end

  // Sticky error flags, cleared only by a new tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o  <= 1'b0;
      align_err_o <= 1'b0;
    end else if (start_i) begin
      overflow_o  <= 1'b0;
      align_err_o <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow_o <= 1'b1;
      end
      if (mis_evt) begin
        align_err_o <= 1'b1;
      end
    end
  end

  // Tile control
  state_t      state_q;
  state_t      state_d;
  logic [15:0] pop_cnt_q;
  logic [15:0] pop_cnt_d;
  logic [15:0] pop_cnt_inc;
  logic [15:0] tile_rows_q;
  logic        done_q;
  logic        done_d;

  assign pop_cnt_inc = pop_cnt_q + 16'd1;
  assign busy_o      = (state_q == ST_BUSY);
  assign done_o      = done_q;

  // Tile registers: state, pop counter, latched row target and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pop_cnt_q   <= '0;
      tile_rows_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pop_cnt_q <= pop_cnt_d;
      done_q    <= done_d;
      if (start_i) begin
        tile_rows_q <= tile_rows_i;
      end
    end
  end

  // Next-state: start (re)arms the tile, the final counted pop ends it with a done pulse.
  always_comb begin
    state_d   = state_q;
    pop_cnt_d = pop_cnt_q;
    done_d    = 1'b0;
    if (start_i) begin
      pop_cnt_d = '0;
      if (tile_rows_i == 16'd0) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_BUSY;
      end
    end else begin
      case (state_q)
        ST_BUSY: begin
          if (pop) begin
            pop_cnt_d = pop_cnt_inc;
            if (pop_cnt_inc == tile_rows_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_psum_collector.sv
module tb_sa_psum_collector;

  localparam int PE = 2;
  localparam int W  = 32;
  localparam int D  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [W*PE-1:0]   psum_row;
  logic [PE-1:0]     psum_en;
  logic              start;
  logic [15:0]       tile_rows;
  logic [W*PE-1:0]   out_row;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              align_err;

  logic [W-1:0] l0;
  logic [W-1:0] l1;
  logic         e0;
  logic         e1;

  assign psum_row = {l0, l1};
  assign psum_en  = {e0, e1};

  int n_vec = 0;
  int n_err = 0;
  int dn;

  always #5 clk = ~clk;

  sa_psum_collector #(
    .PE_SIZE    (PE),
    .PSUM_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .psum_row_i    (psum_row),
    .psum_en_row_i (psum_en),
    .start_i       (start),
    .tile_rows_i   (tile_rows),
    .out_row_o     (out_row),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .busy_o        (busy),
    .done_o        (done),
    .overflow_o    (overflow),
    .align_err_o   (align_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic ea, input logic [W-1:0] b, input logic eb);
    l0 = a;
    e0 = ea;
    l1 = b;
    e1 = eb;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic pulse_start(input logic [15:0] n);
    idle();
    start     = 1'b1;
    tile_rows = n;
    step();
    start     = 1'b0;
  endtask

  function automatic logic [63:0] row2(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a, b};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    tile_rows = 16'd0;
    out_ready = 1'b0;
    idle();
    step();
    step();
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_row",   out_row,        64'h0);
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_done",  64'(done),      64'(0));
    check("rst_ovf",   64'(overflow),  64'(0));
    check("rst_aerr",  64'(align_err), 64'(0));
    rst_n = 1'b1;
    step();

    // Basic alignment: one row, tile of 1
    out_ready = 1'b1;
    pulse_start(16'd1);
    check("b_valid_c0", 64'(out_valid), 64'(0));
    drive(32'h11, 1'b1, 32'h0, 1'b0);
    step();
    check("b_valid_c1", 64'(out_valid), 64'(0));
    drive(32'h0, 1'b0, 32'h22, 1'b1);
    step();
    idle();
    check("b_valid_c2", 64'(out_valid), 64'(1));
    check("b_row_c2",   out_row,        row2(32'h11, 32'h22));
    check("b_busy_c2",  64'(busy),      64'(1));
    check("b_done_c2",  64'(done),      64'(0));
    step();
    check("b_done_c3",  64'(done),      64'(1));
    check("b_busy_c3",  64'(busy),      64'(0));
    check("b_valid_c3", 64'(out_valid), 64'(0));
    check("b_ovf",      64'(overflow),  64'(0));
    check("b_aerr",     64'(align_err), 64'(0));
    step();
    check("b_done_c4",  64'(done),      64'(0));

    // Streaming: eight back-to-back rows 1..8
    pulse_start(16'd8);
    dn = 0;
    for (int c = 0; c <= 12; c++) begin
      if (done) dn++;
      if (c >= 2 && c <= 9) begin
        check("s_valid", 64'(out_valid), 64'(1));
        check("s_row",   out_row,        row2(32'(c-1), 32'(c-1)));
      end
      if (c == 10) check("s_done_c10", 64'(done), 64'(1));
      drive((c < 8) ? 32'(c+1) : 32'h0, c < 8,
            (c >= 1 && c <= 8) ? 32'(c) : 32'h0, c >= 1 && c <= 8);
      step();
    end
    idle();
    check("s_done_cnt", 64'(dn),        64'(1));
    check("s_busy_end", 64'(busy),      64'(0));
    check("s_valid_end",64'(out_valid), 64'(0));

    // Backpressure: five rows into a four-deep FIFO, then push during first pop
    out_ready = 1'b0;
    pulse_start(16'd16);
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) begin
        check("f_ovf_c5",   64'(overflow),  64'(0));
        check("f_valid_c5", 64'(out_valid), 64'(1));
      end
      drive((c < 5) ? 32'(32'hA1 + c) : 32'h0, c < 5,
            (c >= 1) ? 32'(32'hA0 + c) : 32'h0, c >= 1);
      step();
    end
    check("f_ovf_c6", 64'(overflow),  64'(1));
    check("f_row_c6", out_row,        row2(32'hA1, 32'hA1));
    drive(32'hA6, 1'b1, 32'h0, 1'b0);
    step();
    out_ready = 1'b1;
    check("f_row_c7", out_row, row2(32'hA1, 32'hA1));
    drive(32'h0, 1'b0, 32'hA6, 1'b1);
    step();
    idle();
    begin
      logic [W-1:0] exp_q [4];
      exp_q[0] = 32'hA2;
      exp_q[1] = 32'hA3;
      exp_q[2] = 32'hA4;
      exp_q[3] = 32'hA6;
      for (int i = 0; i < 4; i++) begin
        check("f_drain_valid", 64'(out_valid), 64'(1));
        check("f_drain_row",   out_row,        row2(exp_q[i], exp_q[i]));
        step();
      end
    end
    check("f_empty", 64'(out_valid), 64'(0));

    // Misalignment: lane 0 enable only
    pulse_start(16'd1);
    check("m_ovf_clr",  64'(overflow),  64'(0));
    check("m_aerr_c0",  64'(align_err), 64'(0));
    drive(32'h55, 1'b1, 32'h0, 1'b0);
    step();
    idle();
    step();
    check("m_aerr_c2",  64'(align_err), 64'(1));
    check("m_valid_c2", 64'(out_valid), 64'(0));
    step();
    check("m_valid_c3", 64'(out_valid), 64'(0));
    check("m_aerr_c3",  64'(align_err), 64'(1));
    pulse_start(16'd1);
    check("m_aerr_clr", 64'(align_err), 64'(0));

    // Restart: tile of 4, pop two, restart with tile of 2
    out_ready = 1'b0;
    pulse_start(16'd4);
    for (int c = 0; c <= 3; c++) begin
      drive((c < 3) ? 32'(32'h31 + c) : 32'h0, c < 3,
            (c >= 1) ? 32'(32'h30 + c) : 32'h0, c >= 1);
      step();
    end
    idle();
    check("r_row_c4", out_row, row2(32'h31, 32'h31));
    out_ready = 1'b1;
    step();
    check("r_row_c5", out_row, row2(32'h32, 32'h32));
    step();
    out_ready = 1'b0;
    check("r_valid_c6", 64'(out_valid), 64'(1));
    check("r_row_c6",   out_row,        row2(32'h33, 32'h33));
    pulse_start(16'd2);
    check("r_flush",    64'(out_valid), 64'(0));
    check("r_busy",     64'(busy),      64'(1));
    check("r_no_done",  64'(done),      64'(0));
    out_ready = 1'b1;
    dn = 0;
    for (int c = 0; c <= 5; c++) begin
      if (done) dn++;
      if (c == 4) check("r_done_c4", 64'(done), 64'(1));
      drive((c < 2) ? 32'(32'h41 + c) : 32'h0, c < 2,
            (c >= 1 && c <= 2) ? 32'(32'h40 + c) : 32'h0, c >= 1 && c <= 2);
      step();
    end
    idle();
    check("r_done_cnt", 64'(dn),   64'(1));
    check("r_busy_end", 64'(busy), 64'(0));

    // Asynchronous reset mid-tile with data held and a flag set
    out_ready = 1'b0;
    pulse_start(16'd3);
    drive(32'h66, 1'b1, 32'h0, 1'b0);
    step();
    drive(32'h0, 1'b0, 32'h66, 1'b1);
    step();
    drive(32'h77, 1'b1, 32'h0, 1'b0);
    step();
    idle();
    step();
    step();
    check("x_valid_pre", 64'(out_valid), 64'(1));
    check("x_busy_pre",  64'(busy),      64'(1));
    check("x_aerr_pre",  64'(align_err), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("x_valid", 64'(out_valid), 64'(0));
    check("x_row",   out_row,        64'h0);
    check("x_busy",  64'(busy),      64'(0));
    check("x_done",  64'(done),      64'(0));
    check("x_ovf",   64'(overflow),  64'(0));
    check("x_aerr",  64'(align_err), 64'(0));
    #2;
    rst_n = 1'b1;
    step();
    step();
    check("x_busy_after", 64'(busy),      64'(0));
    check("x_valid_after",64'(out_valid), 64'(0));

    // Zero-row tile
    pulse_start(16'd0);
    check("z_done", 64'(done), 64'(1));
    check("z_busy", 64'(busy), 64'(0));
    step();
    check("z_done_off", 64'(done), 64'(0));
    check("z_busy_off", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
